sdm_conv_scheduler: RTL
=======================

SDM_CONV_SCHEDULER -- requirements
Module: sdm_conv_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4: number of requesting channels sharing one sigma-delta accumulate/decimate datapath.
REQ-002 SHALL have parameter BOSR, default 256: bitstream samples accumulated per conversion.
REQ-003 SHALL have parameter WDTH, default 16: result width, unsigned.
REQ-004 SHALL have parameter SETTLE, default 16: bitstream cycles discarded after a channel switch (>=1).
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: en  in  1  scheduler enable.
REQ-008 SHALL have ports: req  in  NCH  per-channel conversion request pulses.
REQ-009 SHALL have ports: adc_bit  in  1  registered comparator bitstream from the front end.
REQ-010 SHALL have ports: mux_sel  out  clog2(NCH)  analog input mux select.
REQ-011 SHALL have ports: grant  out  NCH  one-hot, 1-cycle pulse on grant.
REQ-012 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-013 SHALL have ports: res_data  out  WDTH, res_ch  out  clog2(NCH), res_valid  out  1, res_ready  in  1  (result valid/ready channel).

Function
REQ-014 SHALL keep a pending[NCH] register: req[i]=1 sets pending[i]; a grant to channel i clears it; req[i] in the grant cycle of i leaves pending[i] set.
REQ-015 SHALL implement FSM IDLE, SETTLE, CONVERT, OUTPUT.
REQ-016 IDLE: if en=1 and pending!=0, SHALL grant round-robin (first pending channel after last_ch, wrapping), pulse grant, load mux_sel and last_ch, clear accumulator, load counter, go to SETTLE.
REQ-017 SETTLE: SHALL ignore adc_bit for exactly SETTLE cycles, then go to CONVERT.
REQ-018 CONVERT: SHALL add adc_bit to the accumulator on each of exactly BOSR cycles, saturating at 2^WDTH-1 (no wrap), then go to OUTPUT.
REQ-019 OUTPUT: SHALL drive res_valid=1 with res_data=accumulator and res_ch=mux_sel, held stable until res_valid&&res_ready, then go to IDLE.
REQ-020 Latency: with grant at cycle T, res_valid SHALL first assert at T+SETTLE+BOSR+1.
REQ-021 No new grant SHALL occur while busy=1; mux_sel SHALL change only in grant cycles.
REQ-022 en=0 in SETTLE or CONVERT SHALL abort: next state IDLE, no res_valid, pending[mux_sel] re-set; en=0 in OUTPUT SHALL NOT drop the held result.
REQ-023 en=0 in IDLE SHALL block grants; pending SHALL still capture req.
REQ-024 The grant-cycle-to-IDLE return SHALL allow a back-to-back grant on the cycle after the OUTPUT handshake.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, pending=0, accumulator=0, counter=0, mux_sel=0, last_ch=NCH-1, grant=0, busy=0, res_valid=0, res_data=0, res_ch=0.
REQ-026 Reset asserted mid-conversion SHALL discard the conversion and all pending requests.

Structure
REQ-027 Package sdm_pkg SHALL hold the FSM state enum and default BOSR/WDTH/SETTLE constants.
REQ-028 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs pending, last_ch; outputs one-hot grant, index).

Verification (NCH=4, BOSR=8, SETTLE=2, WDTH=16 unless stated)
REQ-029 Reset: rst_n low mid-CONVERT -> all outputs 0, mux_sel 0, busy 0 immediately, no res_valid afterwards.
REQ-030 req[2] pulse, en=1, adc_bit=1 constant, res_ready=1 -> grant=4'b0100, res_valid at T+11, res_data=8, res_ch=2.
REQ-031 req=4'b1111 in one cycle after reset -> grants in order ch0,ch1,ch2,ch3, four results, adc_bit alternating 1/0 -> each res_data=4.
REQ-032 WDTH=3, BOSR=16, adc_bit=1 -> res_data=7 (saturated).
REQ-033 res_ready low 5 cycles in OUTPUT with req[1] pending -> res_valid/res_data/res_ch stable, no grant until handshake, ch1 grant next cycle after it.
REQ-034 en dropped 3 cycles into CONVERT for ch0 -> no res_valid, pending[0]=1; en raised -> ch0 regranted, full result delivered.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared types and default constants for the sigma-delta conversion scheduler.
package sdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  localparam int DEF_BOSR   = 256;
  localparam int DEF_WDTH   = 16;
  localparam int DEF_SETTLE = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending channel strictly after last_ch, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] pending_i,
  input  logic [CW-1:0]  last_ch_i,
  output logic [NCH-1:0] grant_o,
  output logic [CW-1:0]  idx_o,
  output logic           any_o
);

  always_comb begin
    logic          found;
    int            c;
    logic [CW-1:0] cidx;
    found   = 1'b0;
    c       = 0;
    cidx    = '0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 1; k <= NCH; k++) begin
      c    = (int'(last_ch_i) + k) % NCH;
      cidx = CW'(c);
      if (!found && pending_i[cidx]) begin
        found          = 1'b1;
        idx_o          = cidx;
        grant_o[cidx]  = 1'b1;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sdm_conv_scheduler.sv
// Time-shares one sigma-delta accumulate/decimate datapath across NCH channels:
// round-robin grant, settle discard, BOSR-sample saturating count, held result.
module sdm_conv_scheduler
  import sdm_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int BOSR   = DEF_BOSR,
  parameter int WDTH   = DEF_WDTH,
  parameter int SETTLE = DEF_SETTLE,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NCH-1:0]  req,
  input  logic            adc_bit,
  output logic [CW-1:0]   mux_sel,
  output logic [NCH-1:0]  grant,
  output logic            busy,
  output logic [WDTH-1:0] res_data,
  output logic [CW-1:0]   res_ch,
  output logic            res_valid,
  input  logic            res_ready
);

  localparam int CNTW = $clog2(max_int(BOSR, SETTLE) + 1);

  state_e          state_q;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [WDTH-1:0] acc_q, acc_inc_s;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   mux_sel_q, last_ch_q, res_ch_q;
  logic [NCH-1:0]  grant_q;
  logic            busy_q, res_valid_q;
  logic [WDTH-1:0] res_data_q;

  logic [NCH-1:0]  arb_gnt_s;
  logic [CW-1:0]   arb_idx_s;
  logic            arb_any_s, take_s, abort_s;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .pending_i (pending_q),
    .last_ch_i (last_ch_q),
    .grant_o   (arb_gnt_s),
    .idx_o     (arb_idx_s),
    .any_o     (arb_any_s)
  );

  // A grant may also be taken on the OUTPUT handshake edge so the next channel starts back-to-back.
  assign take_s  = en && arb_any_s &&
                   ((state_q == ST_IDLE) || ((state_q == ST_OUTPUT) && res_ready));
  assign abort_s = !en && ((state_q == ST_SETTLE) || (state_q == ST_CONVERT));

  always_comb begin
    pending_d = pending_q;
    if (take_s) begin
      pending_d = pending_q & ~arb_gnt_s;
    end else if (abort_s) begin
      pending_d[mux_sel_q] = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    pending_d = pending_d | req;
  end

  always_comb begin
    if (adc_bit && (acc_q != {WDTH{1'b1}})) begin
      acc_inc_s = acc_q + WDTH'(1);
    end else begin
      acc_inc_s = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mux_sel_q   <= '0;
      last_ch_q   <= CW'(NCH - 1);
      grant_q     <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      pending_q <= pending_d;
      grant_q   <= '0;
      if (take_s) begin
        grant_q     <= arb_gnt_s;
        mux_sel_q   <= arb_idx_s;
        last_ch_q   <= arb_idx_s;
        acc_q       <= '0;
        cnt_q       <= CNTW'(SETTLE);
        busy_q      <= 1'b1;
        res_valid_q <= 1'b0;
        state_q     <= ST_SETTLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          // cnt starts at SETTLE in the grant cycle, leaving exactly SETTLE discarded samples after it.
          ST_SETTLE: begin
            if (!en) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == '0) begin
              cnt_q   <= CNTW'(BOSR - 1);
              state_q <= ST_CONVERT;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          ST_CONVERT: begin
            if (!en) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == '0) begin
              acc_q       <= acc_inc_s;
              res_data_q  <= acc_inc_s;
              res_ch_q    <= mux_sel_q;
              res_valid_q <= 1'b1;
              state_q     <= ST_OUTPUT;
            end else begin
              acc_q <= acc_inc_s;
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          ST_OUTPUT: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              res_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mux_sel   = mux_sel_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_valid = res_valid_q;

endmodule
